// File: rtl/fifo_seq_checker_if.sv
// fifo_seq_checker_if
//   Bundles the run-control, FIFO-side and result signals of fifo_seq_checker.
//   slave  : checker view (control/FIFO inputs in, pop strobe and results out)
//   master : driver view (the mirror of slave)
//   Control : start_i, len_i, first_i, abort_i, stall_i
//   FIFO    : empty_i, data_i (first-word-fall-through head), pop_o
//   Results : busy_o, done_o, err_o, err_cnt_o, rx_cnt_o, first_bad_o
interface fifo_seq_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
);
  logic                  start_i;
  logic [LEN_WIDTH-1:0]  len_i;
  logic [DATA_WIDTH-1:0] first_i;
  logic                  abort_i;
  logic                  stall_i;
  logic                  empty_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  pop_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [LEN_WIDTH-1:0]  err_cnt_o;
  logic [LEN_WIDTH-1:0]  rx_cnt_o;
  logic [DATA_WIDTH-1:0] first_bad_o;

  modport slave (
    input  start_i, len_i, first_i, abort_i, stall_i, empty_i, data_i,
    output pop_o, busy_o, done_o, err_o, err_cnt_o, rx_cnt_o, first_bad_o
  );

  modport master (
    output start_i, len_i, first_i, abort_i, stall_i, empty_i, data_i,
    input  pop_o, busy_o, done_o, err_o, err_cnt_o, rx_cnt_o, first_bad_o
  );
endinterface

// File: rtl/fifo_seq_checker.sv
// fifo_seq_checker
//   Pops a run of len_i words from a first-word-fall-through FIFO and checks
//   that they form an incrementing sequence starting at first_i. After every
//   pop the expected value resyncs to the popped word + 1, so a single gap
//   counts as one error rather than corrupting the rest of the run.
//   Ports:
//     clk_i  : clock, all state changes on the rising edge
//     rst_i  : synchronous active-high reset
//     bus    : fifo_seq_checker_if.slave
//              start_i/len_i/first_i start a run (accepted only in IDLE)
//              abort_i ends a run without done; stall_i throttles pops
//              empty_i/data_i are the FIFO head, pop_o consumes it
//              busy_o/done_o/err_o/err_cnt_o/rx_cnt_o/first_bad_o report
//              the current or last run and hold in IDLE until next start
module fifo_seq_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  fifo_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

  // Error counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (v == '1) ? v : v + LEN_ONE;
  endfunction

  // Expected value wraps modulo 2^DATA_WIDTH, so all-ones is followed by 0.
  function automatic logic [DATA_WIDTH-1:0] wrap_inc(input logic [DATA_WIDTH-1:0] v);
    return v + DATA_ONE;
  endfunction

  state_t                state_p1;
  logic [LEN_WIDTH-1:0]  len_p1;
  logic [DATA_WIDTH-1:0] exp_p1;
  logic [LEN_WIDTH-1:0]  rx_cnt_p1;
  logic [LEN_WIDTH-1:0]  err_cnt_p1;
  logic [DATA_WIDTH-1:0] first_bad_p1;
  logic                  err_p1;
  logic                  done_p1;
  logic                  busy_p1;

  logic                  pop_p0;
  logic                  mismatch_p0;
  logic                  last_p0;

  // ---- stage p0: combinational pop decision on the FIFO head ----
  // Abort and reset both veto the pop in the same cycle they are seen.
  assign pop_p0      = (state_p1 == RUN) & ~bus.empty_i & ~bus.stall_i
                       & ~bus.abort_i & ~rst_i;
  assign mismatch_p0 = (bus.data_i != exp_p1);
  assign last_p0     = ((rx_cnt_p1 + LEN_ONE) == len_p1);

  // ---- stage p1: registered FSM, counters and result flags ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p1     <= IDLE;
      len_p1       <= '0;
      exp_p1       <= '0;
      rx_cnt_p1    <= '0;
      err_cnt_p1   <= '0;
      first_bad_p1 <= '0;
      err_p1       <= 1'b0;
      done_p1      <= 1'b0;
      busy_p1      <= 1'b0;
    end else begin
      case (state_p1)
        IDLE: begin
          if (bus.start_i) begin
            len_p1       <= bus.len_i;
            exp_p1       <= bus.first_i;
            rx_cnt_p1    <= '0;
            err_cnt_p1   <= '0;
            first_bad_p1 <= '0;
            err_p1       <= 1'b0;
            busy_p1      <= 1'b1;
            if (bus.len_i == '0) begin
              state_p1 <= DONE;
              done_p1  <= 1'b1;
            end else begin
              state_p1 <= RUN;
            end
          end
        end

        RUN: begin
          if (bus.abort_i) begin
            state_p1 <= IDLE;
            busy_p1  <= 1'b0;
          end else if (pop_p0) begin
            rx_cnt_p1 <= rx_cnt_p1 + LEN_ONE;
            exp_p1    <= wrap_inc(bus.data_i);
            if (mismatch_p0) begin
              err_p1     <= 1'b1;
              err_cnt_p1 <= sat_inc(err_cnt_p1);
              if (err_cnt_p1 == '0) begin
                first_bad_p1 <= bus.data_i;
              end
            end
            if (last_p0) begin
              state_p1 <= DONE;
              done_p1  <= 1'b1;
            end
          end
        end

        DONE: begin
          state_p1 <= IDLE;
          done_p1  <= 1'b0;
          busy_p1  <= 1'b0;
        end

        default: begin
          state_p1 <= IDLE;
          done_p1  <= 1'b0;
          busy_p1  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pop_o       = pop_p0;
  assign bus.busy_o      = busy_p1;
  assign bus.done_o      = done_p1;
  assign bus.err_o       = err_p1;
  assign bus.err_cnt_o   = err_cnt_p1;
  assign bus.rx_cnt_o    = rx_cnt_p1;
  assign bus.first_bad_o = first_bad_p1;

endmodule

// File: tb/tb_fifo_seq_checker.sv
// tb_fifo_seq_checker
//   Drives fifo_seq_checker from a queue-backed FIFO model and checks run
//   results against a sequence model computed from the popped words.
module tb_fifo_seq_checker;
  localparam int DW = 32;
  localparam int LW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_seq_checker_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  fifo_seq_checker #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] got_q[$];
  bit            gate_empty;

  task automatic drive_fifo();
    bus.empty_i = gate_empty || (fifo_q.size() == 0);
    bus.data_i  = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
  endtask

  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  // Word i is good when it equals first (i==0) or the previous word + 1.
  function automatic void seq_model(input logic [DW-1:0] first, output int errs,
                                    output logic [DW-1:0] fb);
    logic [DW-1:0] want;
    errs = 0;
    fb   = '0;
    for (int i = 0; i < got_q.size(); i++) begin
      want = (i == 0) ? first : got_q[i-1] + 32'd1;
      if (got_q[i] != want) begin
        if (errs == 0) fb = got_q[i];
        errs++;
      end
    end
  endfunction

  // Starts a run and plays the FIFO until done (+3 cycles), abort or a bound.
  task automatic do_run(input logic [DW-1:0] first, input logic [LW-1:0] len,
                        input int hold_pct, input int abort_after,
                        output int pops, output int dones, output int illegal,
                        output int done_cyc, output int last_pop);
    logic p;
    pops = 0; dones = 0; illegal = 0; done_cyc = -1; last_pop = -1;
    got_q.delete();
    bus.start_i = 1'b1; bus.len_i = len; bus.first_i = first;
    bus.abort_i = 1'b0; bus.stall_i = 1'b0; gate_empty = 1'b0;
    drive_fifo();
    edge_tick();
    bus.start_i = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (bus.done_o === 1'b1) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      bus.abort_i = (abort_after >= 0 && pops == abort_after);
      bus.stall_i = (int'($urandom_range(99)) < hold_pct);
      gate_empty  = (int'($urandom_range(99)) < hold_pct);
      drive_fifo();
      #1;
      p = bus.pop_o;
      if (p && (bus.empty_i || bus.stall_i || bus.abort_i)) illegal++;
      edge_tick();
      if (p === 1'b1) begin
        if (fifo_q.size() != 0) got_q.push_back(fifo_q.pop_front());
        pops++;
        last_pop = cyc;
      end
      if (bus.abort_i) begin
        bus.abort_i = 1'b0;
        break;
      end
    end
    bus.stall_i = 1'b0; gate_empty = 1'b0;
    drive_fifo();
  endtask

  task automatic test_reset();
    int pops;
    rst = 1'b1;
    fifo_q = '{32'h5, 32'h6};
    drive_fifo();
    edge_tick();
    if (bus.pop_o !== 1'b0) begin n_bad++; $display("FAIL reset_pop: got %b want 0", bus.pop_o); end
    n_cmp++;
    edge_tick();
    rst = 1'b0;
    if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_cmp++;
    if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    n_cmp++;
    if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    n_cmp++;
    if (bus.rx_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_rx: got %0d want 0", bus.rx_cnt_o); end
    n_cmp++;
    if (bus.err_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", bus.err_cnt_o); end
    n_cmp++;
    if (bus.first_bad_o !== 32'd0) begin n_bad++; $display("FAIL reset_firstbad: got %0h want 0", bus.first_bad_o); end
    n_cmp++;
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      drive_fifo();
      #1;
      if (bus.pop_o === 1'b1) pops++;
      edge_tick();
    end
    if (pops !== 0) begin n_bad++; $display("FAIL reset_idle_pops: got %0d want 0", pops); end
    n_cmp++;
    fifo_q.delete();
    drive_fifo();
  endtask

  task automatic test_clean_run();
    int pops, dones, illegal, done_cyc, last_pop;
    fifo_q.delete();
    for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(i));
    do_run(32'd0, 32'd16, 0, -1, pops, dones, illegal, done_cyc, last_pop);
    if (pops !== 16) begin n_bad++; $display("FAIL clean_pops: got %0d want 16", pops); end
    n_cmp++;
    if (last_pop !== 15) begin n_bad++; $display("FAIL clean_last_pop_cycle: got %0d want 15", last_pop); end
    n_cmp++;
    if (dones !== 1) begin n_bad++; $display("FAIL clean_done_count: got %0d want 1", dones); end
    n_cmp++;
    if (done_cyc !== 16) begin n_bad++; $display("FAIL clean_done_cycle: got %0d want 16", done_cyc); end
    n_cmp++;
    if (bus.rx_cnt_o !== 32'd16) begin n_bad++; $display("FAIL clean_rx: got %0d want 16", bus.rx_cnt_o); end
    n_cmp++;
    if (bus.err_cnt_o !== 32'd0) begin n_bad++; $display("FAIL clean_errcnt: got %0d want 0", bus.err_cnt_o); end
    n_cmp++;
    if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL clean_err: got %b want 0", bus.err_o); end
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL clean_busy_after: got %b want 0", bus.busy_o); end
    n_cmp++;
  endtask

  task automatic test_gap_resync();
    int pops, dones, illegal, done_cyc, last_pop;
    fifo_q = '{32'd10, 32'd11, 32'd13, 32'd14, 32'd15};
    do_run(32'd10, 32'd5, 0, -1, pops, dones, illegal, done_cyc, last_pop);
    if (bus.err_cnt_o !== 32'd1) begin n_bad++; $display("FAIL gap_errcnt: got %0d want 1", bus.err_cnt_o); end
    n_cmp++;
    if (bus.first_bad_o !== 32'd13) begin n_bad++; $display("FAIL gap_firstbad: got %0d want 13", bus.first_bad_o); end
    n_cmp++;
    if (bus.err_o !== 1'b1) begin n_bad++; $display("FAIL gap_err: got %b want 1", bus.err_o); end
    n_cmp++;
    if (bus.rx_cnt_o !== 32'd5) begin n_bad++; $display("FAIL gap_rx: got %0d want 5", bus.rx_cnt_o); end
    n_cmp++;
    if (dones !== 1) begin n_bad++; $display("FAIL gap_done_count: got %0d want 1", dones); end
    n_cmp++;
  endtask

  task automatic test_wrap();
    int pops, dones, illegal, done_cyc, last_pop;
    fifo_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    do_run(32'hFFFF_FFFE, 32'd4, 0, -1, pops, dones, illegal, done_cyc, last_pop);
    if (bus.err_cnt_o !== 32'd0) begin n_bad++; $display("FAIL wrap_errcnt: got %0d want 0", bus.err_cnt_o); end
    n_cmp++;
    if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL wrap_err: got %b want 0", bus.err_o); end
    n_cmp++;
    if (bus.rx_cnt_o !== 32'd4) begin n_bad++; $display("FAIL wrap_rx: got %0d want 4", bus.rx_cnt_o); end
    n_cmp++;
  endtask

  task automatic test_flow_control();
    int pops, dones, illegal, done_cyc, last_pop;
    fifo_q.delete();
    for (int i = 0; i < 12; i++) fifo_q.push_back(DW'(100 + i));
    do_run(32'd100, 32'd8, 40, -1, pops, dones, illegal, done_cyc, last_pop);
    if (illegal !== 0) begin n_bad++; $display("FAIL flow_pop_while_held: got %0d want 0", illegal); end
    n_cmp++;
    if (pops !== 8) begin n_bad++; $display("FAIL flow_pops: got %0d want 8", pops); end
    n_cmp++;
    if (fifo_q.size() !== 4) begin n_bad++; $display("FAIL flow_fifo_left: got %0d want 4", fifo_q.size()); end
    n_cmp++;
    if (bus.rx_cnt_o !== 32'd8) begin n_bad++; $display("FAIL flow_rx: got %0d want 8", bus.rx_cnt_o); end
    n_cmp++;
    if (dones !== 1) begin n_bad++; $display("FAIL flow_done_count: got %0d want 1", dones); end
    n_cmp++;
    if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL flow_err: got %b want 0", bus.err_o); end
    n_cmp++;
    fifo_q.delete();
  endtask

  task automatic test_len_zero();
    int pops, dones, illegal, done_cyc, last_pop;
    fifo_q = '{32'd7, 32'd8, 32'd9};
    do_run(32'd0, 32'd0, 0, -1, pops, dones, illegal, done_cyc, last_pop);
    if (pops !== 0) begin n_bad++; $display("FAIL len0_pops: got %0d want 0", pops); end
    n_cmp++;
    if (dones !== 1) begin n_bad++; $display("FAIL len0_done_count: got %0d want 1", dones); end
    n_cmp++;
    if (done_cyc !== 0) begin n_bad++; $display("FAIL len0_done_cycle: got %0d want 0", done_cyc); end
    n_cmp++;
    if (bus.rx_cnt_o !== 32'd0) begin n_bad++; $display("FAIL len0_rx: got %0d want 0", bus.rx_cnt_o); end
    n_cmp++;
    fifo_q.delete();
  endtask

  task automatic test_abort();
    int pops, dones, illegal, done_cyc, last_pop, idle_pops, idle_dones;
    fifo_q = '{32'd0, 32'd1, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
    do_run(32'd0, 32'd10, 0, 3, pops, dones, illegal, done_cyc, last_pop);
    if (pops !== 3) begin n_bad++; $display("FAIL abort_pops: got %0d want 3", pops); end
    n_cmp++;
    if (illegal !== 0) begin n_bad++; $display("FAIL abort_pop_in_abort_cycle: got %0d want 0", illegal); end
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy_o); end
    n_cmp++;
    if (bus.rx_cnt_o !== 32'd3) begin n_bad++; $display("FAIL abort_rx: got %0d want 3", bus.rx_cnt_o); end
    n_cmp++;
    if (bus.err_cnt_o !== 32'd1) begin n_bad++; $display("FAIL abort_errcnt: got %0d want 1", bus.err_cnt_o); end
    n_cmp++;
    if (bus.first_bad_o !== 32'd5) begin n_bad++; $display("FAIL abort_firstbad: got %0d want 5", bus.first_bad_o); end
    n_cmp++;
    // Abort and random traffic while idle must leave all results untouched.
    idle_pops = 0; idle_dones = dones;
    for (int i = 0; i < 5; i++) begin
      bus.abort_i = 1'b1;
      bus.stall_i = 1'($urandom);
      drive_fifo();
      #1;
      if (bus.pop_o === 1'b1) idle_pops++;
      edge_tick();
      if (bus.done_o === 1'b1) idle_dones++;
    end
    bus.abort_i = 1'b0; bus.stall_i = 1'b0;
    if (idle_dones !== 0) begin n_bad++; $display("FAIL abort_done_seen: got %0d want 0", idle_dones); end
    n_cmp++;
    if (idle_pops !== 0) begin n_bad++; $display("FAIL idle_pops: got %0d want 0", idle_pops); end
    n_cmp++;
    if (bus.rx_cnt_o !== 32'd3 || bus.err_o !== 1'b1) begin
      n_bad++; $display("FAIL idle_hold: got rx=%0d err=%b want rx=3 err=1", bus.rx_cnt_o, bus.err_o);
    end
    n_cmp++;
    fifo_q.delete();
    drive_fifo();
  endtask

  task automatic test_reset_mid_run();
    int pops, idle_pops;
    logic p;
    fifo_q.delete();
    for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(i));
    bus.start_i = 1'b1; bus.len_i = 32'd10; bus.first_i = 32'd0;
    drive_fifo();
    edge_tick();
    bus.len_i = 32'd1; bus.first_i = 32'h99;
    pops = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      bus.start_i = (pops == 2);
      drive_fifo();
      #1;
      p = bus.pop_o;
      edge_tick();
      if (p === 1'b1) begin
        void'(fifo_q.pop_front());
        pops++;
      end
      if (pops == 5) break;
    end
    bus.start_i = 1'b0;
    if (bus.rx_cnt_o !== 32'd5 || bus.busy_o !== 1'b1 || bus.err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL start_in_run_ignored: got rx=%0d busy=%b err=%b want rx=5 busy=1 err=0",
               bus.rx_cnt_o, bus.busy_o, bus.err_o);
    end
    n_cmp++;
    rst = 1'b1;
    drive_fifo();
    #1;
    if (bus.pop_o !== 1'b0) begin n_bad++; $display("FAIL midrst_pop: got %b want 0", bus.pop_o); end
    n_cmp++;
    edge_tick();
    rst = 1'b0;
    if (bus.rx_cnt_o !== 32'd0 || bus.err_cnt_o !== 32'd0 || bus.err_o !== 1'b0 ||
        bus.first_bad_o !== 32'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got rx=%0d errcnt=%0d err=%b fb=%0h busy=%b done=%b want all 0",
               bus.rx_cnt_o, bus.err_cnt_o, bus.err_o, bus.first_bad_o, bus.busy_o, bus.done_o);
    end
    n_cmp++;
    idle_pops = 0;
    for (int i = 0; i < 4; i++) begin
      drive_fifo();
      #1;
      if (bus.pop_o === 1'b1) idle_pops++;
      edge_tick();
    end
    if (idle_pops !== 0) begin n_bad++; $display("FAIL midrst_idle_pops: got %0d want 0", idle_pops); end
    n_cmp++;
    fifo_q.delete();
    drive_fifo();
  endtask

  task automatic test_random_runs();
    int pops, dones, illegal, done_cyc, last_pop, m_errs, len;
    logic [DW-1:0] first, w, m_fb;
    for (int r = 0; r < 6; r++) begin
      len   = int'($urandom_range(20, 1));
      first = DW'($urandom);
      if (r == 0) first = 32'hFFFF_FFF8;
      fifo_q.delete();
      w = first;
      for (int i = 0; i < len + 3; i++) begin
        if ($urandom_range(4) == 0) w = DW'($urandom);
        fifo_q.push_back(w);
        w = w + 32'd1;
      end
      do_run(first, LW'(len), 30, -1, pops, dones, illegal, done_cyc, last_pop);
      seq_model(first, m_errs, m_fb);
      if (pops !== len || illegal !== 0 || dones !== 1) begin
        n_bad++;
        $display("FAIL rand%0d_flow: got pops=%0d illegal=%0d dones=%0d want pops=%0d illegal=0 dones=1",
                 r, pops, illegal, dones, len);
      end
      n_cmp++;
      if (bus.rx_cnt_o !== LW'(len)) begin n_bad++; $display("FAIL rand%0d_rx: got %0d want %0d", r, bus.rx_cnt_o, len); end
      n_cmp++;
      if (bus.err_cnt_o !== LW'(m_errs)) begin n_bad++; $display("FAIL rand%0d_errcnt: got %0d want %0d", r, bus.err_cnt_o, m_errs); end
      n_cmp++;
      if (bus.err_o !== (m_errs != 0)) begin n_bad++; $display("FAIL rand%0d_err: got %b want %b", r, bus.err_o, (m_errs != 0)); end
      n_cmp++;
      if (bus.first_bad_o !== m_fb) begin n_bad++; $display("FAIL rand%0d_firstbad: got %0h want %0h", r, bus.first_bad_o, m_fb); end
      n_cmp++;
    end
    fifo_q.delete();
    drive_fifo();
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.len_i = '0; bus.first_i = '0;
    bus.abort_i = 1'b0; bus.stall_i = 1'b0;
    gate_empty = 1'b0;
    drive_fifo();
    test_reset();
    test_clean_run();
    test_gap_resync();
    test_wrap();
    test_flow_control();
    test_len_zero();
    test_abort();
    test_reset_mid_run();
    test_random_runs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule
